// File: rtl/lcd_time_writer.sv
// HD44780 8-bit writer: powers up the LCD, then redraws "MC:DU" at line 1 col 0
// whenever the BCD digit set differs from the last one displayed.
module lcd_time_writer #(
    parameter int T_PWR = 750000,
    parameter int T_E   = 12,
    parameter int T_CMD = 2000,
    parameter int T_CLR = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] mil,
    input  logic [3:0] cen,
    input  logic [3:0] dec,
    input  logic [3:0] uni,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       ready
);
    localparam int MAX_A = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int MAX_B = (T_CMD > T_E) ? T_CMD : T_E;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWR - 1);
    localparam logic [CW-1:0] E_LAST   = CW'(T_E - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(T_CLR - 1);

    typedef enum logic [1:0] {PWR_WAIT, INIT, REFRESH, IDLE} state_t;
    typedef enum logic [1:0] {SETUP, E_HIGH, E_WAIT} phase_t;

    state_t        state;
    phase_t        phase;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [15:0]   snap;
    logic [15:0]   live;
    logic [CW-1:0] wait_last;

    assign live   = {mil, cen, dec, uni};
    assign lcd_rw = 1'b0;
    // Only the clear command needs the long settle time.
    assign wait_last = (lcd_data == 8'h01 && !lcd_rs) ? CLR_LAST : CMD_LAST;

    function automatic logic [7:0] to_char(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h2D;
    endfunction

    // {rs, data} for each init byte
    function automatic logic [8:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0:    return 9'h038;
            3'd1:    return 9'h00C;
            3'd2:    return 9'h006;
            default: return 9'h001;
        endcase
    endfunction

    // Refresh bytes 1..5 come from the snapshot; byte 0 (0x80) is loaded on entry.
    function automatic logic [8:0] refresh_byte(input logic [2:0] i, input logic [15:0] s);
        case (i)
            3'd1:    return {1'b1, to_char(s[15:12])};
            3'd2:    return {1'b1, to_char(s[11:8])};
            3'd3:    return {1'b1, 8'h3A};
            3'd4:    return {1'b1, to_char(s[7:4])};
            default: return {1'b1, to_char(s[3:0])};
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PWR_WAIT;
            phase    <= SETUP;
            idx      <= '0;
            cnt      <= '0;
            snap     <= 16'h0000;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
            ready    <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        state              <= INIT;
                        phase              <= SETUP;
                        idx                <= '0;
                        cnt                <= '0;
                        {lcd_rs, lcd_data} <= init_byte(3'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (live != snap) begin
                        state              <= REFRESH;
                        phase              <= SETUP;
                        snap               <= live;
                        idx                <= '0;
                        {lcd_rs, lcd_data} <= 9'h080;
                        ready              <= 1'b0;
                    end
                end
                default: begin
                    case (phase)
                        SETUP: begin
                            lcd_e <= 1'b1;
                            phase <= E_HIGH;
                            cnt   <= '0;
                        end
                        E_HIGH: begin
                            if (cnt == E_LAST) begin
                                lcd_e <= 1'b0;
                                phase <= E_WAIT;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt != wait_last) begin
                                cnt <= cnt + 1'b1;
                            end else begin
                                cnt   <= '0;
                                phase <= SETUP;
                                if (state == INIT) begin
                                    if (idx == 3'd3) begin
                                        state              <= REFRESH;
                                        snap               <= live;
                                        idx                <= '0;
                                        {lcd_rs, lcd_data} <= 9'h080;
                                    end else begin
                                        idx                <= idx + 3'd1;
                                        {lcd_rs, lcd_data} <= init_byte(idx + 3'd1);
                                    end
                                end else if (idx == 3'd5) begin
                                    state <= IDLE;
                                    ready <= 1'b1;
                                end else begin
                                    idx                <= idx + 3'd1;
                                    {lcd_rs, lcd_data} <= refresh_byte(idx + 3'd1, snap);
                                end
                            end
                        end
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_time_writer.sv
// Directed bench for lcd_time_writer: a negedge monitor logs every E pulse,
// and per-scenario tasks compare the log against hand-computed byte streams.
module tb_lcd_time_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] mil = 4'd1, cen = 4'd2, dec = 4'd3, uni = 4'd4;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e, ready;

    lcd_time_writer #(.T_PWR(20), .T_E(2), .T_CMD(5), .T_CLR(10)) dut (
        .clk(clk), .reset(reset), .mil(mil), .cen(cen), .dec(dec), .uni(uni),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // monitor log
    logic [8:0] byte_q[$];
    int         rise_q[$];
    int         width_q[$];
    int         rdy_rise_q[$];
    int         rdy_fall_q[$];
    int         stab_bad = 0;
    int         rw_bad = 0;
    logic       e_prev = 0, r_prev = 0, chg_prev = 0, chg;
    logic [8:0] last_bus = '0;
    int         hw = 0;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (reset) begin
            e_prev = 0; r_prev = 0; chg_prev = 0; last_bus = '0; hw = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                byte_q.push_back({lcd_rs, lcd_data});
                rise_q.push_back(cyc);
                hw = 0;
            end
            if (lcd_e) hw++;
            if (!lcd_e && e_prev) width_q.push_back(hw);
            // bus may only change in the SETUP cycle right before an E rise
            if (chg_prev && !(lcd_e && !e_prev)) stab_bad++;
            chg = ({lcd_rs, lcd_data} !== last_bus);
            if (chg && lcd_e) stab_bad++;
            chg_prev = chg;
            last_bus = {lcd_rs, lcd_data};
            e_prev = lcd_e;
            if (ready && !r_prev) rdy_rise_q.push_back(cyc);
            if (!ready && r_prev) rdy_fall_q.push_back(cyc);
            r_prev = ready;
        end
    end

    task automatic clear_log();
        byte_q.delete(); rise_q.delete(); width_q.delete();
        rdy_rise_q.delete(); rdy_fall_q.delete();
        stab_bad = 0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (byte_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (ready === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic release_reset(output int rel);
        @(posedge clk); #1;
        reset = 1'b0;
        rel = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({lcd_e, lcd_rs, lcd_rw, ready, lcd_data} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got e=%b rs=%b rw=%b rdy=%b data=%h, want all zero",
                     lcd_e, lcd_rs, lcd_rw, ready, lcd_data);
        end
    endtask

    // Shared by power-up and post-reset: checks the full init + first refresh stream.
    task automatic check_startup(input string tag, input logic [7:0] c1, c2, c4, c5);
        int rel; bit ok;
        logic [8:0] exp [10];
        int off [10];
        exp = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080,
                {1'b1, c1}, {1'b1, c2}, 9'h13A, {1'b1, c4}, {1'b1, c5}};
        off = '{21, 29, 37, 45, 58, 66, 74, 82, 90, 98};
        clear_log();
        release_reset(rel);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (lcd_e !== 1'b0 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_pwr_wait: got e=%b rdy=%b, want 0 0", tag, lcd_e, ready);
        end
        wait_bytes(10, 400, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_byte_timeout: got %0d bytes, want 10", tag, byte_q.size()); end
        wait_ready(100, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_ready_timeout: got ready=%b, want 1", tag, ready); end
        if (byte_q.size() == 10 && rise_q.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (byte_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL %s_byte%0d: got %h, want %h", tag, i, byte_q[i], exp[i]);
                end
                n_cmp++;
                if (rise_q[i] - rel !== off[i]) begin
                    n_bad++;
                    $display("FAIL %s_rise%0d: got offset %0d, want %0d", tag, i, rise_q[i] - rel, off[i]);
                end
            end
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL %s_count: got %0d bytes, want 10", tag, byte_q.size());
        end
        n_cmp++;
        if (width_q.size() != 10) begin
            n_bad++;
            $display("FAIL %s_pulse_count: got %0d, want 10", tag, width_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (width_q[i] !== 2) begin
                    n_bad++;
                    $display("FAIL %s_e_width%0d: got %0d, want 2", tag, i, width_q[i]);
                end
            end
        end
        n_cmp++;
        if (rdy_rise_q.size() != 1 || rdy_rise_q[0] - rel != 105) begin
            n_bad++;
            $display("FAIL %s_ready_rise: got %0d rises (first offset %0d), want 1 at 105",
                     tag, rdy_rise_q.size(), rdy_rise_q.size() > 0 ? rdy_rise_q[0] - rel : -1);
        end
        n_cmp++;
        if (stab_bad !== 0) begin
            n_bad++;
            $display("FAIL %s_bus_stable: got %0d violations, want 0", tag, stab_bad);
        end
    endtask

    task automatic test_power_up();
        check_startup("power_up", 8'h31, 8'h32, 8'h33, 8'h34);
        n_cmp++;
        if (rw_bad !== 0) begin n_bad++; $display("FAIL rw_low: got %0d samples high, want 0", rw_bad); end
    endtask

    task automatic test_refresh_change();
        bit ok;
        logic [8:0] exp [6];
        exp = '{9'h080, 9'h131, 9'h132, 9'h13A, 9'h133, 9'h135};
        clear_log();
        @(negedge clk); #1;
        uni = 4'd5;
        wait_bytes(6, 200, ok);
        wait_ready(100, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL refresh_ready_timeout: got ready=%b, want 1", ready); end
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (byte_q.size() != 6) begin
            n_bad++;
            $display("FAIL refresh_count: got %0d bytes, want 6", byte_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (byte_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL refresh_byte%0d: got %h, want %h", i, byte_q[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (rdy_fall_q.size() != 1 || rdy_rise_q.size() != 1 || rdy_rise_q[0] - rdy_fall_q[0] != 48) begin
            n_bad++;
            $display("FAIL refresh_ready_low: got falls=%0d rises=%0d, want 1 and 1 with 48-cycle low",
                     rdy_fall_q.size(), rdy_rise_q.size());
        end
        n_cmp++;
        if (stab_bad !== 0) begin n_bad++; $display("FAIL refresh_bus_stable: got %0d, want 0", stab_bad); end
    endtask

    task automatic test_change_mid_refresh();
        bit ok;
        logic [8:0] exp [12];
        exp = '{9'h080, 9'h131, 9'h132, 9'h13A, 9'h136, 9'h135,
                9'h080, 9'h131, 9'h132, 9'h13A, 9'h137, 9'h135};
        clear_log();
        @(negedge clk); #1;
        dec = 4'd6;
        wait_bytes(4, 200, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL mid_start_timeout: got %0d bytes, want 4", byte_q.size()); end
        dec = 4'd7;
        wait_bytes(12, 300, ok);
        wait_ready(100, ok);
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (byte_q.size() != 12) begin
            n_bad++;
            $display("FAIL mid_count: got %0d bytes, want 12", byte_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if (byte_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL mid_byte%0d: got %h, want %h", i, byte_q[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (rdy_rise_q.size() != 2 || rdy_fall_q.size() != 2 || rdy_fall_q[1] - rdy_rise_q[0] != 1) begin
            n_bad++;
            $display("FAIL mid_ready_pulse: got rises=%0d falls=%0d, want 2 and 2 with 1-cycle pulse",
                     rdy_rise_q.size(), rdy_fall_q.size());
        end
    endtask

    task automatic test_invalid_digit();
        bit ok;
        logic [8:0] exp [6];
        exp = '{9'h080, 9'h12D, 9'h132, 9'h13A, 9'h137, 9'h135};
        clear_log();
        @(negedge clk); #1;
        mil = 4'hC;
        wait_bytes(6, 200, ok);
        wait_ready(100, ok);
        n_cmp++;
        if (byte_q.size() != 6) begin
            n_bad++;
            $display("FAIL invalid_count: got %0d bytes, want 6", byte_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (byte_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL invalid_byte%0d: got %h, want %h", i, byte_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        clear_log();
        @(negedge clk); #1;
        uni = 4'd9;
        wait_bytes(2, 200, ok);
        n_cmp++;
        if (!ok || lcd_e !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_e_high: got e=%b, want 1", lcd_e);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({lcd_e, lcd_rs, lcd_rw, ready, lcd_data} !== 12'h000) begin
            n_bad++;
            $display("FAIL midrst_async: got e=%b rs=%b rw=%b rdy=%b data=%h, want all zero",
                     lcd_e, lcd_rs, lcd_rw, ready, lcd_data);
        end
        repeat (3) @(negedge clk);
        check_startup("post_reset", 8'h2D, 8'h32, 8'h37, 8'h39);
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_refresh_change();
        test_change_mid_refresh();
        test_invalid_digit();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
